// File: rtl/ps2_ascii_decoder.sv
// PS/2 set-2 scan-code to ASCII decoder with prefix tracking, modifier state
// and a small character FIFO for CPU reads.
module ps2_ascii_decoder #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] key_data,
  input  logic       ready,
  output logic       ps2_rdn,
  input  logic       cpu_rdn,
  output logic [6:0] ascii,
  output logic       ascii_ready,
  output logic       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] ST_NORMAL  = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
  localparam logic [1:0] ST_EXT     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  logic       r_ps2_rdn;
  logic [7:0] r_code;
  logic       r_code_v;
  logic [1:0] r_state;
  logic       r_lshift;
  logic       r_rshift;
  logic       r_caps;
  logic       r_overflow;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic [6:0] r_mem [DEPTH];

  logic [8:0] w_map;
  logic       w_make;
  logic       w_push;
  logic [6:0] w_char;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_wr_en;

  // Scan-code map: {valid, is_letter, lower-case character}
  function automatic logic [8:0] map_code(input logic [7:0] c);
    logic [8:0] m;
    m = '0;
    case (c)
      8'h1C: m = {2'b11, 7'h61}; 8'h32: m = {2'b11, 7'h62};
      8'h21: m = {2'b11, 7'h63}; 8'h23: m = {2'b11, 7'h64};
      8'h24: m = {2'b11, 7'h65}; 8'h2B: m = {2'b11, 7'h66};
      8'h34: m = {2'b11, 7'h67}; 8'h33: m = {2'b11, 7'h68};
      8'h43: m = {2'b11, 7'h69}; 8'h3B: m = {2'b11, 7'h6A};
      8'h42: m = {2'b11, 7'h6B}; 8'h4B: m = {2'b11, 7'h6C};
      8'h3A: m = {2'b11, 7'h6D}; 8'h31: m = {2'b11, 7'h6E};
      8'h44: m = {2'b11, 7'h6F}; 8'h4D: m = {2'b11, 7'h70};
      8'h15: m = {2'b11, 7'h71}; 8'h2D: m = {2'b11, 7'h72};
      8'h1B: m = {2'b11, 7'h73}; 8'h2C: m = {2'b11, 7'h74};
      8'h3C: m = {2'b11, 7'h75}; 8'h2A: m = {2'b11, 7'h76};
      8'h1D: m = {2'b11, 7'h77}; 8'h22: m = {2'b11, 7'h78};
      8'h35: m = {2'b11, 7'h79}; 8'h1A: m = {2'b11, 7'h7A};
      8'h45: m = {2'b10, 7'h30}; 8'h16: m = {2'b10, 7'h31};
      8'h1E: m = {2'b10, 7'h32}; 8'h26: m = {2'b10, 7'h33};
      8'h25: m = {2'b10, 7'h34}; 8'h2E: m = {2'b10, 7'h35};
      8'h36: m = {2'b10, 7'h36}; 8'h3D: m = {2'b10, 7'h37};
      8'h3E: m = {2'b10, 7'h38}; 8'h46: m = {2'b10, 7'h39};
      8'h29: m = {2'b10, 7'h20}; 8'h5A: m = {2'b10, 7'h0D};
      8'h66: m = {2'b10, 7'h08};
      default: m = '0;
    endcase
    return m;
  endfunction

  // Decode and FIFO handshake terms
  always_comb begin
    w_map   = map_code(r_code);
    w_make  = r_code_v && (r_state == ST_NORMAL) && (r_code != 8'hF0) && (r_code != 8'hE0);
    w_push  = w_make && w_map[8];
    w_char  = (w_map[7] && ((r_lshift | r_rshift) ^ r_caps)) ? (w_map[6:0] - 7'h20) : w_map[6:0];
    w_empty = (r_wr_ptr == r_rd_ptr);
    w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    w_pop   = !cpu_rdn && !w_empty;
    w_wr_en = w_push && (!w_full || w_pop);
  end

  // Fetch handshake: one-cycle pop pulse, then a decode cycle
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ps2_rdn <= 1'b1;
      r_code_v  <= 1'b0;
      r_code    <= '0;
    end else if (ready && r_ps2_rdn) begin
      r_code    <= key_data;
      r_code_v  <= 1'b1;
      r_ps2_rdn <= 1'b0;
    end else begin
      r_ps2_rdn <= 1'b1;
      r_code_v  <= 1'b0;
    end
  end

  // Prefix FSM and modifier state, advanced on decode cycles only
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state  <= ST_NORMAL;
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_caps   <= 1'b0;
    end else if (r_code_v) begin
      case (r_state)
        ST_NORMAL: begin
          if (r_code == 8'hF0)      r_state <= ST_BRK;
          else if (r_code == 8'hE0) r_state <= ST_EXT;
          else if (r_code == 8'h12) r_lshift <= 1'b1;
          else if (r_code == 8'h59) r_rshift <= 1'b1;
          else if (r_code == 8'h58) r_caps <= ~r_caps;
        end
        ST_BRK: begin
          if (r_code == 8'h12) r_lshift <= 1'b0;
          if (r_code == 8'h59) r_rshift <= 1'b0;
          r_state <= ST_NORMAL;
        end
        ST_EXT:  r_state <= (r_code == 8'hF0) ? ST_EXT_BRK : ST_NORMAL;
        default: r_state <= ST_NORMAL;
      endcase
    end
  end

  // FIFO pointers and sticky overflow
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // FIFO storage; when full, a same-cycle pop frees the slot being written
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_char;
  end

  assign ps2_rdn     = r_ps2_rdn;
  assign ascii_ready = !w_empty;
  assign ascii       = w_empty ? 7'h00 : r_mem[r_rd_ptr[AW-1:0]];
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// Directed bench for ps2_ascii_decoder.
module tb_ps2_ascii_decoder;

  logic       clk = 1'b0;
  logic       clrn = 1'b1;
  logic [7:0] key_data = 8'h00;
  logic       ready = 1'b0;
  logic       ps2_rdn;
  logic       cpu_rdn = 1'b1;
  logic [6:0] ascii;
  logic       ascii_ready;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  ps2_ascii_decoder #(.DEPTH(8)) dut (
    .clk(clk), .clrn(clrn), .key_data(key_data), .ready(ready),
    .ps2_rdn(ps2_rdn), .cpu_rdn(cpu_rdn), .ascii(ascii),
    .ascii_ready(ascii_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Called #1 after a posedge; fetch edge then decode edge
  task automatic send_byte(input logic [7:0] b, input bit pop_on_decode);
    key_data = b;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    if (pop_on_decode) cpu_rdn = 1'b0;
    @(posedge clk); #1;
    cpu_rdn = 1'b1;
  endtask

  task automatic cpu_pop();
    cpu_rdn = 1'b0;
    @(posedge clk); #1;
    cpu_rdn = 1'b1;
  endtask

  task automatic test_reset();
    #1 clrn = 1'b0;
    #1;
    checks++;
    if ({ps2_rdn, ascii_ready, ascii, overflow} !== {1'b1, 1'b0, 7'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs got rdn=%b rdy=%b ascii=%h ovf=%b want 1 0 00 0",
               ps2_rdn, ascii_ready, ascii, overflow);
    end
    @(posedge clk); @(negedge clk);
    clrn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_key();
    int lows;
    key_data = 8'h1C;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    checks++;
    if (ps2_rdn !== 1'b0 || ascii_ready !== 1'b0) begin
      errors++;
      $display("FAIL fetch_edge got rdn=%b rdy=%b want 0 0", ps2_rdn, ascii_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (ps2_rdn !== 1'b1 || ascii_ready !== 1'b1 || ascii !== 7'h61) begin
      errors++;
      $display("FAIL decode_edge got rdn=%b rdy=%b ascii=%h want 1 1 61", ps2_rdn, ascii_ready, ascii);
    end
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ps2_rdn === 1'b0) lows++;
    end
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL single_pulse got extra_lows=%0d want 0", lows);
    end
    cpu_pop();
    checks++;
    if (ascii_ready !== 1'b0 || ascii !== 7'h00) begin
      errors++;
      $display("FAIL pop_to_empty got rdy=%b ascii=%h want 0 00", ascii_ready, ascii);
    end
  endtask

  task automatic test_shift();
    logic [7:0] s [7] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    logic [6:0] e [2] = '{7'h41, 7'h61};
    foreach (s[i]) send_byte(s[i], 1'b0);
    foreach (e[i]) begin
      checks++;
      if (ascii_ready !== 1'b1 || ascii !== e[i]) begin
        errors++;
        $display("FAIL shift_char%0d got rdy=%b ascii=%h want 1 %h", i, ascii_ready, ascii, e[i]);
      end
      cpu_pop();
    end
    checks++;
    if (ascii_ready !== 1'b0) begin
      errors++;
      $display("FAIL shift_empty got rdy=%b want 0", ascii_ready);
    end
  endtask

  task automatic test_caps();
    logic [7:0] s [5] = '{8'h58, 8'h1C, 8'h12, 8'h1C, 8'h16};
    logic [7:0] r [4] = '{8'hF0, 8'h12, 8'h58, 8'h1C};
    logic [6:0] e [4] = '{7'h41, 7'h61, 7'h31, 7'h61};
    foreach (s[i]) send_byte(s[i], 1'b0);
    // release shift, toggle caps off, then a plain letter
    foreach (r[i]) send_byte(r[i], 1'b0);
    foreach (e[i]) begin
      checks++;
      if (ascii_ready !== 1'b1 || ascii !== e[i]) begin
        errors++;
        $display("FAIL caps_char%0d got rdy=%b ascii=%h want 1 %h", i, ascii_ready, ascii, e[i]);
      end
      cpu_pop();
    end
    checks++;
    if (ascii_ready !== 1'b0) begin
      errors++;
      $display("FAIL caps_empty got rdy=%b want 0", ascii_ready);
    end
  endtask

  task automatic test_prefixes();
    logic [7:0] s [9] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h1C, 8'h66, 8'h1C};
    logic [6:0] e [2] = '{7'h08, 7'h61};
    foreach (s[i]) send_byte(s[i], 1'b0);
    foreach (e[i]) begin
      checks++;
      if (ascii_ready !== 1'b1 || ascii !== e[i]) begin
        errors++;
        $display("FAIL prefix_char%0d got rdy=%b ascii=%h want 1 %h", i, ascii_ready, ascii, e[i]);
      end
      cpu_pop();
    end
    checks++;
    if (ascii_ready !== 1'b0) begin
      errors++;
      $display("FAIL prefix_empty got rdy=%b want 0", ascii_ready);
    end
  endtask

  task automatic test_overflow();
    int bad;
    for (int i = 0; i < 8; i++) send_byte(8'h16, 1'b0);
    checks++;
    if (overflow !== 1'b0 || ascii_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_no_ovf got ovf=%b rdy=%b want 0 1", overflow, ascii_ready);
    end
    send_byte(8'h16, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got %b want 1", overflow);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (ascii_ready !== 1'b1 || ascii !== 7'h31) bad++;
      cpu_pop();
    end
    checks++;
    if (bad !== 0 || ascii_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain got bad=%0d rdy=%b want 0 0", bad, ascii_ready);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got %b want 1", overflow);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    for (int i = 0; i < 8; i++) send_byte(8'h16, 1'b0);
    send_byte(8'h1E, 1'b1);
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      if (ascii_ready !== 1'b1 || ascii !== 7'h31) bad++;
      cpu_pop();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL pushpop_ones got bad=%0d want 0", bad);
    end
    checks++;
    if (ascii_ready !== 1'b1 || ascii !== 7'h32) begin
      errors++;
      $display("FAIL pushpop_last got rdy=%b ascii=%h want 1 32", ascii_ready, ascii);
    end
    cpu_pop();
    checks++;
    if (ascii_ready !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_empty got rdy=%b want 0", ascii_ready);
    end
  endtask

  task automatic test_reset_mid_fetch();
    send_byte(8'h12, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h1C, 1'b0);
    checks++;
    if (ascii_ready !== 1'b1 || ascii !== 7'h41) begin
      errors++;
      $display("FAIL prereset_head got rdy=%b ascii=%h want 1 41", ascii_ready, ascii);
    end
    key_data = 8'h16;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    checks++;
    if (ps2_rdn !== 1'b0) begin
      errors++;
      $display("FAIL midfetch_low got %b want 0", ps2_rdn);
    end
    clrn = 1'b0;
    #1;
    checks++;
    if ({ps2_rdn, ascii_ready, ascii, overflow} !== {1'b1, 1'b0, 7'h00, 1'b0}) begin
      errors++;
      $display("FAIL midreset_outputs got rdn=%b rdy=%b ascii=%h ovf=%b want 1 0 00 0",
               ps2_rdn, ascii_ready, ascii, overflow);
    end
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ascii_ready !== 1'b0) begin
      errors++;
      $display("FAIL discard_latched got rdy=%b want 0", ascii_ready);
    end
    send_byte(8'h1C, 1'b0);
    checks++;
    if (ascii_ready !== 1'b1 || ascii !== 7'h61) begin
      errors++;
      $display("FAIL shift_cleared got rdy=%b ascii=%h want 1 61", ascii_ready, ascii);
    end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_shift();
    test_caps();
    test_prefixes();
    test_overflow();
    test_back_to_back();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
